// File: rtl/axi_lite_uart_master.sv
// UART debug bridge: decodes 'W'/'R' byte frames from the host into single AXI-Lite
// transactions and streams back a status byte (plus read data for reads).
module axi_lite_uart_master #(
  parameter int ADDR_W       = 12,
  parameter int BYTE_TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              busy,
  output logic              rx_drop
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    SEND
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;
  localparam logic [7:0] RSP_BAD   = 8'h3F;

  // One spare count of headroom keeps the width valid when the timeout is 0 or 1.
  localparam int              TW          = $clog2(BYTE_TIMEOUT + 2);
  localparam logic [TW-1:0]   TIMEOUT_VAL = TW'(BYTE_TIMEOUT);

  state_t              state_q, state_d;
  logic                is_write_q, is_write_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]          addr_hi_q, addr_hi_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [31:0]         resp_buf_q, resp_buf_d;
  logic [2:0]          remaining_q, remaining_d;
  logic                rx_drop_q, rx_drop_d;

  logic [15:0]         addr_full;
  logic [TW-1:0]       timer_next;
  logic                timer_expired;
  logic                aw_done;
  logic                w_done;

  always_comb begin
    state_d       = state_q;
    is_write_d    = is_write_q;
    byte_cnt_d    = byte_cnt_q;
    addr_hi_d     = addr_hi_q;
    timer_d       = timer_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    resp_buf_d    = resp_buf_q;
    remaining_d   = remaining_q;
    rx_drop_d     = 1'b0;

    addr_full     = {addr_hi_q, rx_data};
    timer_next    = timer_q + TW'(1);
    timer_expired = (BYTE_TIMEOUT != 0) && (timer_next == TIMEOUT_VAL);
    aw_done       = !awvalid_q || m_axi_awready;
    w_done        = !wvalid_q || m_axi_wready;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          byte_cnt_d = 2'd0;
          timer_d    = '0;
          if (rx_data == CMD_WRITE) begin
            is_write_d = 1'b1;
            state_d    = GET_ADDR;
          end else if (rx_data == CMD_READ) begin
            is_write_d = 1'b0;
            state_d    = GET_ADDR;
          end else begin
            tx_valid_d  = 1'b1;
            tx_data_d   = RSP_BAD;
            remaining_d = 3'd0;
            state_d     = SEND;
          end
        end
      end

      GET_ADDR: begin
        if (rx_valid) begin
          timer_d = '0;
          if (byte_cnt_q == 2'd0) begin
            addr_hi_d  = rx_data;
            byte_cnt_d = 2'd1;
          end else begin
            byte_cnt_d = 2'd0;
            if (is_write_q) begin
              awaddr_d = ADDR_W'(addr_full);
              state_d  = GET_DATA;
            end else begin
              araddr_d  = ADDR_W'(addr_full);
              arvalid_d = 1'b1;
              state_d   = RD_REQ;
            end
          end
        end else if (BYTE_TIMEOUT != 0) begin
          timer_d = timer_next;
          if (timer_expired) begin
            state_d = IDLE;
          end
        end
      end

      GET_DATA: begin
        if (rx_valid) begin
          timer_d    = '0;
          wdata_d    = {wdata_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wstrb_d   = 4'hF;
            state_d   = WR_REQ;
          end
        end else if (BYTE_TIMEOUT != 0) begin
          timer_d = timer_next;
          if (timer_expired) begin
            state_d = IDLE;
          end
        end
      end

      // AW and W retire independently; the response phase starts once both have.
      WR_REQ: begin
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && m_axi_wready) begin
          wvalid_d = 1'b0;
        end
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_d    = 1'b0;
          tx_valid_d  = 1'b1;
          tx_data_d   = (m_axi_bresp == 2'b00) ? RSP_OK : RSP_ERR;
          remaining_d = 3'd0;
          state_d     = SEND;
        end
      end

      RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end

      RD_RESP: begin
        if (m_axi_rvalid) begin
          rready_d    = 1'b0;
          tx_valid_d  = 1'b1;
          tx_data_d   = (m_axi_rresp == 2'b00) ? RSP_OK : RSP_ERR;
          resp_buf_d  = m_axi_rdata;
          remaining_d = 3'd4;
          state_d     = SEND;
        end
      end

      // Read data leaves MSB first by shifting the buffer one byte per accept.
      SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (remaining_q == 3'd0) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            tx_data_d   = resp_buf_q[31:24];
            resp_buf_d  = {resp_buf_q[23:0], 8'h00};
            remaining_d = remaining_q - 3'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (rx_valid && (state_q != IDLE) && (state_q != GET_ADDR) && (state_q != GET_DATA)) begin
      rx_drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= 2'd0;
      addr_hi_q   <= 8'h00;
      timer_q     <= '0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      resp_buf_q  <= 32'h0;
      remaining_q <= 3'd0;
      rx_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_hi_q   <= addr_hi_d;
      timer_q     <= timer_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      resp_buf_q  <= resp_buf_d;
      remaining_q <= remaining_d;
      rx_drop_q   <= rx_drop_d;
    end
  end

  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign busy          = (state_q != IDLE);
  assign rx_drop       = rx_drop_q;

endmodule
